// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage plus the IF/ID pipeline register. Issues word
//   fetches over a valid/ready request channel, buffers returned words in a
//   small FIFO and hands them to decode as instrD/PCD/PCplus4D/validD.
//   Decode stalls are absorbed by the FIFO. Redirects from execute restart
//   fetch at the target and discard responses still in flight.
//
//   Optional feature: define FETCH_PERF_EN to add the fetch_bubbles output,
//   a saturating count of cycles where decode received a starvation bubble
//   (FIFO empty, no flush, no stall).
//
// Parameters
//   RESET_PC    first fetch address after reset
//   FIFO_DEPTH  response buffer entries; also the cap on outstanding+buffered
//   NOP_INSTR   bubble instruction presented on instrD
//
// Ports
//   clk             in   rising-edge clock
//   rst             in   asynchronous reset, active-low
//   stallD          in   hold IF/ID register
//   flushD          in   replace IF/ID contents with a bubble
//   PCSrcE          in   redirect request from execute
//   PCTargetE       in   redirect target (bits [1:0] ignored)
//   imem_req_valid  out  fetch request valid
//   imem_req_ready  in   memory accepts request
//   imem_addr       out  word-aligned fetch address
//   imem_rsp_valid  in   response valid (in request order)
//   imem_rsp_data   in   response instruction word
//   instrD          out  IF/ID instruction
//   PCD             out  IF/ID PC
//   PCplus4D        out  IF/ID PC+4
//   validD          out  IF/ID holds a real instruction
//   fetch_bubbles   out  starvation bubble count (FETCH_PERF_EN only)
//
// State      | meaning
// -----------+------------------------------------------------------------
// RESET_WAIT | one idle cycle after reset release, no requests
// FETCH      | issuing requests while credits remain, buffering responses
// DRAIN      | after a redirect: no requests, dropping stale responses
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] instrD,
    output logic [31:0] PCD,
    output logic [31:0] PCplus4D,
    output logic        validD
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_bubbles
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW:0]   CREDITS  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic [1:0] {
        RESET_WAIT = 2'd0,
        FETCH      = 2'd1,
        DRAIN      = 2'd2
    } stateT;

    stateT         state;
    logic [31:0]   fpc;
    logic [31:0]   rspPc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] outAfterRsp;
    logic [CW-1:0] fifoCount;
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [31:0]   fifoData [FIFO_DEPTH];
    logic [31:0]   fifoPc   [FIFO_DEPTH];
    logic [CW:0]   creditsUsed;
    logic [31:0]   redirTarget;
    logic [31:0]   headPc;
    logic          reqFire;
    logic          rspLive;
    logic          push;
    logic          pop;
    logic          fifoEmpty;
    logic          ifidKill;
    logic          unusedTgtBits;

    function automatic logic [PW-1:0] ptrNext(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    assign redirTarget   = {PCTargetE[31:2], 2'b00};
    assign unusedTgtBits = ^PCTargetE[1:0];

    // Credits cover both in-flight requests and words already buffered, so
    // every response has a FIFO slot waiting for it.
    assign creditsUsed    = (CW + 1)'(outstanding) + (CW + 1)'(fifoCount);
    assign imem_req_valid = (state == FETCH) && (creditsUsed < CREDITS) && !PCSrcE;
    assign imem_addr      = fpc;
    assign reqFire        = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error; ignore it
    // rather than let the counters wrap.
    assign rspLive     = imem_rsp_valid && (outstanding != '0);
    assign outAfterRsp = outstanding - CW'(rspLive);

    assign push      = (state == FETCH) && rspLive && !PCSrcE;
    assign fifoEmpty = (fifoCount == '0);
    assign ifidKill  = flushD || PCSrcE;
    assign pop       = !ifidKill && !stallD && !fifoEmpty;
    assign headPc    = fifoPc[rdPtr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RESET_WAIT;
            fpc         <= RESET_PC;
            rspPc       <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            case (state)
                RESET_WAIT: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (PCSrcE) begin
                        // A response landing in the redirect cycle is stale
                        // and consumed here, so it is not counted in discard.
                        fpc         <= redirTarget;
                        rspPc       <= redirTarget;
                        outstanding <= outAfterRsp;
                        discard     <= outAfterRsp;
                        state       <= (outAfterRsp != '0) ? DRAIN : FETCH;
                    end else begin
                        if (reqFire) begin
                            fpc <= fpc + 32'd4;
                        end
                        if (push) begin
                            rspPc <= rspPc + 32'd4;
                        end
                        if (reqFire && !rspLive) begin
                            outstanding <= outstanding + CNT_ONE;
                        end else if (!reqFire && rspLive) begin
                            outstanding <= outstanding - CNT_ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (PCSrcE) begin
                        fpc   <= redirTarget;
                        rspPc <= redirTarget;
                    end
                    if (rspLive) begin
                        outstanding <= outAfterRsp;
                    end
                    if (rspLive && (discard != '0)) begin
                        discard <= discard - CNT_ONE;
                    end
                    if ((discard == '0) || (rspLive && (discard == CNT_ONE))) begin
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= RESET_WAIT;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; a redirect empties the buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            fifoCount <= '0;
        end else if (PCSrcE) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (push) begin
                wrPtr <= ptrNext(wrPtr);
            end
            if (pop) begin
                rdPtr <= ptrNext(rdPtr);
            end
            if (push && !pop) begin
                fifoCount <= fifoCount + CNT_ONE;
            end else if (pop && !push) begin
                fifoCount <= fifoCount - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoData[wrPtr] <= imem_rsp_data;
            fifoPc[wrPtr]   <= rspPc;
        end
    end

    // IF/ID register. A flush leaves PCD/PCplus4D untouched; only the
    // instruction and valid flag are replaced.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instrD   <= NOP_INSTR;
            PCD      <= 32'h0000_0000;
            PCplus4D <= 32'h0000_0000;
            validD   <= 1'b0;
        end else if (ifidKill) begin
            instrD <= NOP_INSTR;
            validD <= 1'b0;
        end else if (stallD) begin
            instrD   <= instrD;
            PCD      <= PCD;
            PCplus4D <= PCplus4D;
            validD   <= validD;
        end else if (!fifoEmpty) begin
            instrD   <= fifoData[rdPtr];
            PCD      <= headPc;
            PCplus4D <= headPc + 32'd4;
            validD   <= 1'b1;
        end else begin
            instrD <= NOP_INSTR;
            validD <= 1'b0;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_bubbles <= 32'h0000_0000;
        end else if (!ifidKill && !stallD && fifoEmpty && (fetch_bubbles != 32'hFFFF_FFFF)) begin
            fetch_bubbles <= fetch_bubbles + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst && push && !pop) begin
            assert (fifoCount != CNT_FULL);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stallD;
    logic        flushD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instrD;
    logic [31:0] PCD;
    logic [31:0] PCplus4D;
    logic        validD;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_bubbles;
`endif

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stallD         (stallD),
        .flushD         (flushD),
        .PCSrcE         (PCSrcE),
        .PCTargetE      (PCTargetE),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instrD         (instrD),
        .PCD            (PCD),
        .PCplus4D       (PCplus4D),
        .validD         (validD)
`ifdef FETCH_PERF_EN
        ,
        .fetch_bubbles  (fetch_bubbles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory model state: in-order queue of addresses with due cycles.
    logic [31:0] memQ [$];
    int          dueQ [$];
    int          cycle;
    int          lat;
    logic [31:0] lastReqAddr;
    logic [31:0] expPc;
    int          nPass;
    int          nChecks;
`ifdef FETCH_PERF_EN
    logic [31:0] bubbleBase;
`endif

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one clock. Handshake is sampled late in the cycle; after the
    // edge the memory model drives the next due response.
    task automatic tick();
        logic        hs;
        logic [31:0] a;
        #2;
        hs = imem_req_valid && imem_req_ready;
        a  = imem_addr;
        @(posedge clk);
        #1;
        if (hs) begin
            memQ.push_back(a);
            dueQ.push_back(cycle + lat);
            lastReqAddr = a;
        end
        cycle++;
        if (dueQ.size() > 0 && dueQ[0] <= cycle) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memWord(memQ[0]);
            void'(memQ.pop_front());
            void'(dueQ.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    endtask

    // Wait (bounded) for the next valid IF/ID entry and check it is expPc.
    task automatic expectNext(input string tag);
        int n;
        n = 0;
        tick();
        while (validD !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check({tag, ".valid"}, {31'b0, validD}, 32'd1);
        check({tag, ".pc"}, PCD, expPc);
        check({tag, ".instr"}, instrD, memWord(expPc));
        check({tag, ".pc4"}, PCplus4D, expPc + 32'd4);
        expPc = expPc + 32'd4;
    endtask

    initial begin
        int nb;
        nPass          = 0;
        nChecks        = 0;
        cycle          = 0;
        lat            = 1;
        lastReqAddr    = 32'h0;
        expPc          = 32'h0;
        rst            = 1'b1;
        stallD         = 1'b0;
        flushD         = 1'b0;
        PCSrcE         = 1'b0;
        PCTargetE      = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset values
        check("rst.instr", instrD, 32'h0000_0013);
        check("rst.valid", {31'b0, validD}, 32'd0);
        check("rst.pc", PCD, 32'h0);
        check("rst.pc4", PCplus4D, 32'h0);
        check("rst.req", {31'b0, imem_req_valid}, 32'd0);

        // Release: one RESET_WAIT cycle, then fetch 0, 4
        rst = 1'b1;
        #1;
        check("wait.req", {31'b0, imem_req_valid}, 32'd0);
        tick();
        check("f0.req", {31'b0, imem_req_valid}, 32'd1);
        check("f0.addr", imem_addr, 32'h0);
        tick();
        check("f1.req", {31'b0, imem_req_valid}, 32'd1);
        check("f1.addr", imem_addr, 32'h4);
        tick();
        check("f2.credit", {31'b0, imem_req_valid}, 32'd0);
        check("f2.valid", {31'b0, validD}, 32'd0);
        tick();
        check("first.valid", {31'b0, validD}, 32'd1);
        check("first.pc", PCD, 32'h0);
        check("first.instr", instrD, memWord(32'h0));
        check("first.pc4", PCplus4D, 32'h4);
        expPc = 32'h4;
        expectNext("stream");
        expectNext("stream");
        expectNext("stream");

        // Stall three cycles: IF/ID frozen, credits run out
        stallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall.pc", PCD, expPc - 32'd4);
            check("stall.instr", instrD, memWord(expPc - 32'd4));
            check("stall.valid", {31'b0, validD}, 32'd1);
            if (i >= 1) check("stall.credit", {31'b0, imem_req_valid}, 32'd0);
        end
        stallD = 1'b0;
        expectNext("poststall");
        expectNext("poststall");
        expectNext("poststall");

        // Memory not ready for five cycles
        imem_req_ready = 1'b0;
        nb = 0;
`ifdef FETCH_PERF_EN
        bubbleBase = fetch_bubbles;
`endif
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rdy0.addr", imem_addr, lastReqAddr + 32'd4);
            if (validD === 1'b1) begin
                check("rdy0.pc", PCD, expPc);
                expPc = expPc + 32'd4;
            end else begin
                nb++;
            end
        end
        check("rdy0.drained", {31'b0, validD}, 32'd0);
`ifdef FETCH_PERF_EN
        check("rdy0.bubbles", fetch_bubbles - bubbleBase, 32'(nb));
`endif

        // Redirect with two outstanding at latency 3
        lat = 3;
        imem_req_ready = 1'b1;
        #1;
        check("redir.req0", {31'b0, imem_req_valid}, 32'd1);
        tick();
        tick();
        check("redir.full", {31'b0, imem_req_valid}, 32'd0);
        PCSrcE    = 1'b1;
        PCTargetE = 32'h0000_0103;
        tick();
        PCSrcE = 1'b0;
        #1;
        check("redir.bubble", {31'b0, validD}, 32'd0);
        check("redir.drain0", {31'b0, imem_req_valid}, 32'd0);
        tick();
        check("redir.drain1", {31'b0, imem_req_valid}, 32'd0);
        check("redir.drainv", {31'b0, validD}, 32'd0);
        tick();
        check("redir.req", {31'b0, imem_req_valid}, 32'd1);
        check("redir.addr", imem_addr, 32'h0000_0100);
        expPc = 32'h0000_0100;
        expectNext("redir");
        expectNext("redir");

        // Redirect coinciding with the only outstanding response
        imem_req_ready = 1'b0;
        lat = 1;
        repeat (8) tick();
        check("idle.valid", {31'b0, validD}, 32'd0);
        imem_req_ready = 1'b1;
        tick();
        PCSrcE    = 1'b1;
        PCTargetE = 32'h0000_0200;
        #1;
        check("same.gate", {31'b0, imem_req_valid}, 32'd0);
        check("same.rsp", {31'b0, imem_rsp_valid}, 32'd1);
        tick();
        PCSrcE = 1'b0;
        #1;
        check("same.nodrain", {31'b0, imem_req_valid}, 32'd1);
        check("same.addr", imem_addr, 32'h0000_0200);
        expPc = 32'h0000_0200;
        expectNext("same");

        // Flush while stalled with a full FIFO
        stallD = 1'b1;
        repeat (3) tick();
        flushD = 1'b1;
        tick();
        check("flush.instr", instrD, 32'h0000_0013);
        check("flush.valid", {31'b0, validD}, 32'd0);
        check("flush.pc", PCD, 32'h0000_0200);
        check("flush.pc4", PCplus4D, 32'h0000_0204);
        flushD = 1'b0;
        stallD = 1'b0;
        tick();
        check("flush.next.valid", {31'b0, validD}, 32'd1);
        check("flush.next.pc", PCD, 32'h0000_0204);
        check("flush.next.instr", instrD, memWord(32'h0000_0204));

        // PC wrap at the top of the address space
        PCSrcE    = 1'b1;
        PCTargetE = 32'hFFFF_FFFB;
        tick();
        PCSrcE = 1'b0;
        expPc = 32'hFFFF_FFF8;
        expectNext("wrap");
        expectNext("wrap");
        expectNext("wrap");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
